int_logarithm: RTL

//  Inverse of the exponentiation unit: given base X and value R, returns Y = floor(log_X(R)),
//  i.e. the largest Y with X^Y <= R, plus an exact flag (X^Y == R).

---
 rtl/int_log_pkg.sv | 17 +
 rtl/int_log_shift_add_mult.sv | 49 ++++
 rtl/int_logarithm.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/int_log_pkg.sv
// Shared definitions for the integer logarithm unit: operand widths and FSM state encoding.
package int_log_pkg;

   localparam int W_BASE = 8;
   localparam int W_VAL  = 128;
   localparam int LOG_W  = 7;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      MSTART,
      MWAIT,
      CMP,
      DONE
   } int_log_state_t;

endpackage

// File: rtl/int_log_shift_add_mult.sv
// Serial W_A x W_B shift-add multiplier: one multiplier bit per cycle, done pulses
// W_A cycles after start; the full product is valid from the cycle after done.
module shift_add_mult
   import int_log_pkg::*;
#(
   parameter int W_A = W_BASE,
   parameter int W_B = W_VAL
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [W_A-1:0]     a,
   input  logic [W_B-1:0]     b,
   output logic               done,
   output logic [W_A+W_B-1:0] product
);

   localparam int W_CNT = $clog2(W_A + 1);

   logic [W_A-1:0]     r_mplier;
   logic [W_A+W_B-1:0] r_mcand;
   logic [W_A+W_B-1:0] r_prod;
   logic [W_CNT-1:0]   r_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_mplier <= '0;
         r_mcand  <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
      end else if (start) begin
         r_mplier <= a;
         r_mcand  <= {{W_A{1'b0}}, b};
         r_prod   <= '0;
         r_cnt    <= W_CNT'(W_A);
      end else if (r_cnt != '0) begin
         // LSB-first: add the shifted multiplicand for each set multiplier bit
         if (r_mplier[0])
            r_prod <= r_prod + r_mcand;
         r_mplier <= r_mplier >> 1;
         r_mcand  <= r_mcand << 1;
         r_cnt    <= r_cnt - 1'b1;
      end
   end

   assign done    = (r_cnt == W_CNT'(1));
   assign product = r_prod;

endmodule

// File: rtl/int_logarithm.sv
// Y = floor(log_X(R)) by repeated multiplication; exact flag when X^Y == R.
// Define INT_LOG_POWER_OUT_EN to add the power_out port carrying X^Y.
module int_logarithm
   import int_log_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [W_BASE-1:0] X,
   input  logic [W_VAL-1:0]  R,
`ifdef INT_LOG_POWER_OUT_EN
   output logic [W_VAL-1:0]  power_out,
`endif
   output logic              busy,
   output logic              end_log,
   output logic [LOG_W-1:0]  log_out,
   output logic              exact,
   output logic              error
);

   int_log_state_t r_state;
   int_log_state_t w_state_next;

   logic [W_BASE-1:0]       r_x;
   logic [W_VAL-1:0]        r_r;
   logic [W_VAL-1:0]        r_acc;
   logic [LOG_W-1:0]        r_cnt;

   logic                    w_mult_start;
   logic                    w_mult_done;
   logic [W_VAL+W_BASE-1:0] w_product;

   logic                    w_accept;
   logic                    w_bad;
   logic                    w_exceeds;
   logic                    w_load_out;
   logic [LOG_W-1:0]        w_res_log;
   logic                    w_res_exact;
   logic                    w_res_err;
`ifdef INT_LOG_POWER_OUT_EN
   logic [W_VAL-1:0]        w_res_pow;
`endif

   shift_add_mult #(
      .W_A (W_BASE),
      .W_B (W_VAL)
   ) u_mult (
      .clock   (clock),
      .reset   (reset),
      .start   (w_mult_start),
      .a       (r_x),
      .b       (r_acc),
      .done    (w_mult_done),
      .product (w_product)
   );

   assign w_accept  = (r_state == IDLE) && start;
   assign w_bad     = (r_x < W_BASE'(2)) || (r_r == '0);
   // Next power either spills past W_VAL bits or exceeds R: acc is the answer
   assign w_exceeds = (|w_product[W_VAL+W_BASE-1:W_VAL]) || (w_product[W_VAL-1:0] > r_r);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = CHECK;
         CHECK:   w_state_next = w_bad ? DONE : MSTART;
         MSTART:  w_state_next = MWAIT;
         MWAIT:   if (w_mult_done) w_state_next = CMP;
         CMP:     w_state_next = w_exceeds ? DONE : MSTART;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_mult_start = (r_state == MSTART);
      w_load_out   = 1'b0;
      w_res_log    = '0;
      w_res_exact  = 1'b0;
      w_res_err    = 1'b0;
`ifdef INT_LOG_POWER_OUT_EN
      w_res_pow    = '0;
`endif
      if (r_state == CHECK && w_bad) begin
         w_load_out = 1'b1;
         w_res_err  = 1'b1;
      end else if (r_state == CMP && w_exceeds) begin
         w_load_out  = 1'b1;
         w_res_log   = r_cnt;
         w_res_exact = (r_acc == r_r);
`ifdef INT_LOG_POWER_OUT_EN
         w_res_pow   = r_acc;
`endif
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_x   <= '0;
         r_r   <= '0;
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_x   <= X;
         r_r   <= R;
         r_acc <= W_VAL'(1);
         r_cnt <= '0;
      end else if (r_state == CMP && !w_exceeds) begin
         r_acc <= w_product[W_VAL-1:0];
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Results land on the edge entering DONE, so end_log is high for the DONE cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy    <= 1'b0;
         end_log <= 1'b0;
         log_out <= '0;
         exact   <= 1'b0;
         error   <= 1'b0;
`ifdef INT_LOG_POWER_OUT_EN
         power_out <= '0;
`endif
      end else begin
         end_log <= w_load_out;
         if (w_accept)
            busy <= 1'b1;
         else if (w_load_out)
            busy <= 1'b0;
         if (w_load_out) begin
            log_out <= w_res_log;
            exact   <= w_res_exact;
            error   <= w_res_err;
`ifdef INT_LOG_POWER_OUT_EN
            power_out <= w_res_pow;
`endif
         end
      end
   end

endmodule
